ghost_sprite_engine: RTL and testbench

Parametrised multi-ghost engine. It replaces the single fixed ghost instance with NUM_GHOSTS ghosts. Each ghost gets per-frame chase/scatter movement, a pixel-level sprite hit and colour output with fixed priority, and Pacman collision detection that drives game_over. It sits between the VGA controller and color_mapper, in the 25 MHz pixel clock domain.

---
 rtl/ghost_sprite_engine.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_ghost_sprite_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ghost_sprite_engine.sv
// Multi-ghost engine: per-frame chase/scatter movement, sprite pixel hit, collision.
// Optional frightened mode enabled by defining GHOST_FRIGHTENED_EN.
module ghost_sprite_engine #(
    parameter int NUM_GHOSTS  = 4,
    parameter int SPRITE_SIZE = 16,
    parameter int COORD_W     = 10,
    parameter int SPEED       = 1,
    parameter int MODE_FRAMES = 420,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int HOME_X      = 288,
    parameter int HOME_Y      = 224
`ifdef GHOST_FRIGHTENED_EN
    ,
    parameter int FRIGHT_FRAMES = 300
`endif
) (
    input  logic                          Clk,
    input  logic                          reset_rtl_0,
    input  logic                          frame_tick,
    input  logic                          start,
    input  logic [COORD_W-1:0]            draw_x,
    input  logic [COORD_W-1:0]            draw_y,
    input  logic                          draw_valid,
    input  logic [COORD_W-1:0]            pacman_x,
    input  logic [COORD_W-1:0]            pacman_y,
`ifdef GHOST_FRIGHTENED_EN
    input  logic                          power_pellet,
    output logic                          ghost_eaten,
`endif
    output logic [NUM_GHOSTS*COORD_W-1:0] ghost_x,
    output logic [NUM_GHOSTS*COORD_W-1:0] ghost_y,
    output logic                          pix_hit,
    output logic [2:0]                    pix_id,
    output logic [3:0]                    pix_red,
    output logic [3:0]                    pix_green,
    output logic [3:0]                    pix_blue,
    output logic                          mode,
    output logic                          game_over,
    output logic [2:0]                    collision_id
);

    localparam int IW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam int TW = (MODE_FRAMES > 1) ? $clog2(MODE_FRAMES) : 1;
    localparam int DW = COORD_W + 2;
    localparam int GW = NUM_GHOSTS * COORD_W;
    localparam logic [COORD_W-1:0] MAX_X = COORD_W'(SCREEN_W - SPRITE_SIZE);
    localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(SCREEN_H - SPRITE_SIZE);

    function automatic logic [GW-1:0] home_xs();
        logic [GW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_GHOSTS; i++)
            v[i*COORD_W +: COORD_W] = COORD_W'(HOME_X + i * SPRITE_SIZE);
        return v;
    endfunction

    function automatic logic [GW-1:0] home_ys();
        logic [GW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_GHOSTS; i++)
            v[i*COORD_W +: COORD_W] = COORD_W'(HOME_Y);
        return v;
    endfunction

    localparam logic [GW-1:0] HOME_XV = home_xs();
    localparam logic [GW-1:0] HOME_YV = home_ys();

    function automatic logic [11:0] palette(input int i);
        logic [11:0] c;
        unique case (i % 4)
            0:       c = 12'hF00;
            1:       c = 12'hFBB;
            2:       c = 12'h0FF;
            default: c = 12'hFB4;
        endcase
        return c;
    endfunction

    function automatic logic [COORD_W-1:0] clampc(
        input logic signed [DW-1:0] v,
        input logic [COORD_W-1:0]   mx
    );
        if (v < 0)
            return '0;
        if (v > $signed({2'b00, mx}))
            return mx;
        return v[COORD_W-1:0];
    endfunction

    function automatic logic signed [DW-1:0] sabs(input logic signed [DW-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_UPDATE,
        S_CHECK,
        S_OVER
    } state_t;

    state_t                  state_q;
    logic [IW-1:0]           idx_q;
    logic                    tick_q;
    logic [TW-1:0]           timer_q;
    logic                    mode_q;
    logic [GW-1:0]           gx_q, gy_q;
    logic                    game_over_q;
    logic [2:0]              coll_q;
    logic                    hit_q;
    logic [2:0]              id_q;
    logic [11:0]             rgb_q;
    logic [NUM_GHOSTS-1:0]   fright_q;
`ifdef GHOST_FRIGHTENED_EN
    localparam int FW = $clog2(FRIGHT_FRAMES + 1);
    logic [FW-1:0]           fcnt_q;
    logic                    eaten_q;
`endif

    logic                    frame_edge;
    assign frame_edge = frame_tick & ~tick_q;

    // Movement of the ghost selected by idx_q.
    logic [COORD_W-1:0]      cur_gx, cur_gy, tx, ty;
    logic [COORD_W-1:0]      nx_d, ny_d;
    logic [1:0]              corner;
    logic                    flee;
    logic signed [DW-1:0]    dx, dy, adx, ady, stp, sgn_x, sgn_y;

    always_comb begin
        cur_gx = gx_q[idx_q*COORD_W +: COORD_W];
        cur_gy = gy_q[idx_q*COORD_W +: COORD_W];
        corner = 2'(idx_q);
        flee   = fright_q[idx_q];
        if (mode_q || flee) begin
            tx = pacman_x;
            ty = pacman_y;
        end else begin
            tx = corner[0] ? MAX_X : '0;
            ty = corner[1] ? MAX_Y : '0;
        end
        dx    = $signed({2'b00, tx}) - $signed({2'b00, cur_gx});
        dy    = $signed({2'b00, ty}) - $signed({2'b00, cur_gy});
        adx   = sabs(dx);
        ady   = sabs(dy);
        sgn_x = ((dx > 0) ^ flee) ? DW'(1) : -DW'(1);
        sgn_y = ((dy > 0) ^ flee) ? DW'(1) : -DW'(1);
        nx_d  = cur_gx;
        ny_d  = cur_gy;
        stp   = '0;
        if (adx >= ady && adx != 0) begin
            stp  = (adx < DW'(SPEED)) ? adx : DW'(SPEED);
            nx_d = clampc($signed({2'b00, cur_gx}) + sgn_x * stp, MAX_X);
        end else if (ady != 0) begin
            stp  = (ady < DW'(SPEED)) ? ady : DW'(SPEED);
            ny_d = clampc($signed({2'b00, cur_gy}) + sgn_y * stp, MAX_Y);
        end
    end

    // Pacman overlap per ghost, lowest index reported.
    logic [NUM_GHOSTS-1:0]   ovl, danger, eat;
    logic [2:0]              danger_id;
    logic signed [DW-1:0]    ox, oy;

    always_comb begin
        ovl = '0;
        ox  = '0;
        oy  = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            ox = $signed({2'b00, gx_q[i*COORD_W +: COORD_W]})
               - $signed({2'b00, pacman_x});
            oy = $signed({2'b00, gy_q[i*COORD_W +: COORD_W]})
               - $signed({2'b00, pacman_y});
            ovl[i] = (sabs(ox) < DW'(SPRITE_SIZE))
                   && (sabs(oy) < DW'(SPRITE_SIZE));
        end
        danger    = ovl & ~fright_q;
        eat       = ovl & fright_q;
        danger_id = '0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--)
            if (danger[i])
                danger_id = 3'(i);
    end

    // Sprite hit for the current pixel; the descending loop lets index 0 win.
    logic                    hit_d;
    logic [2:0]              id_d;
    logic [11:0]             rgb_d;
    logic [COORD_W:0]        px, py, lx, ly;

    always_comb begin
        hit_d = 1'b0;
        id_d  = '0;
        rgb_d = '0;
        px    = {1'b0, draw_x};
        py    = {1'b0, draw_y};
        lx    = '0;
        ly    = '0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            lx = {1'b0, gx_q[i*COORD_W +: COORD_W]};
            ly = {1'b0, gy_q[i*COORD_W +: COORD_W]};
            if (draw_valid
                && px >= lx && px < lx + (COORD_W+1)'(SPRITE_SIZE)
                && py >= ly && py < ly + (COORD_W+1)'(SPRITE_SIZE)) begin
                hit_d = 1'b1;
                id_d  = 3'(i);
                rgb_d = fright_q[i] ? 12'h00F : palette(i);
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            tick_q      <= 1'b0;
            timer_q     <= '0;
            mode_q      <= 1'b0;
            gx_q        <= HOME_XV;
            gy_q        <= HOME_YV;
            game_over_q <= 1'b0;
            coll_q      <= '0;
            hit_q       <= 1'b0;
            id_q        <= '0;
            rgb_q       <= '0;
            fright_q    <= '0;
`ifdef GHOST_FRIGHTENED_EN
            fcnt_q      <= '0;
            eaten_q     <= 1'b0;
`endif
        end else begin
            tick_q <= frame_tick;
            hit_q  <= hit_d;
            id_q   <= id_d;
            rgb_q  <= rgb_d;
`ifdef GHOST_FRIGHTENED_EN
            eaten_q <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        mode_q  <= 1'b0;
                        timer_q <= '0;
                    end
                end
                S_RUN: begin
                    if (frame_edge) begin
                        state_q <= S_UPDATE;
                        idx_q   <= '0;
`ifdef GHOST_FRIGHTENED_EN
                        if (fcnt_q != '0) begin
                            fcnt_q <= fcnt_q - 1'b1;
                            if (fcnt_q == FW'(1))
                                fright_q <= '0;
                        end else
`endif
                        if (timer_q == TW'(MODE_FRAMES - 1)) begin
                            timer_q <= '0;
                            mode_q  <= ~mode_q;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
`ifdef GHOST_FRIGHTENED_EN
                    if (power_pellet) begin
                        fcnt_q   <= FW'(FRIGHT_FRAMES);
                        fright_q <= '1;
                    end
`endif
                end
                S_UPDATE: begin
                    gx_q[idx_q*COORD_W +: COORD_W] <= nx_d;
                    gy_q[idx_q*COORD_W +: COORD_W] <= ny_d;
                    if (idx_q == IW'(NUM_GHOSTS - 1))
                        state_q <= S_CHECK;
                    else
                        idx_q <= idx_q + 1'b1;
                end
                S_CHECK: begin
                    if (|danger) begin
                        state_q     <= S_OVER;
                        game_over_q <= 1'b1;
                        coll_q      <= danger_id;
                    end else begin
                        state_q <= S_RUN;
`ifdef GHOST_FRIGHTENED_EN
                        for (int i = 0; i < NUM_GHOSTS; i++) begin
                            if (eat[i]) begin
                                gx_q[i*COORD_W +: COORD_W] <= HOME_XV[i*COORD_W +: COORD_W];
                                gy_q[i*COORD_W +: COORD_W] <= HOME_YV[i*COORD_W +: COORD_W];
                                fright_q[i] <= 1'b0;
                            end
                        end
                        eaten_q <= |eat;
`endif
                    end
                end
                S_OVER: begin
                    if (start) begin
                        state_q     <= S_RUN;
                        gx_q        <= HOME_XV;
                        gy_q        <= HOME_YV;
                        game_over_q <= 1'b0;
                        mode_q      <= 1'b0;
                        timer_q     <= '0;
                        fright_q    <= '0;
`ifdef GHOST_FRIGHTENED_EN
                        fcnt_q      <= '0;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef GHOST_FRIGHTENED_EN
    assign ghost_eaten = eaten_q;
`else
    logic unused_eat;
    assign unused_eat = |eat;
`endif

    assign ghost_x      = gx_q;
    assign ghost_y      = gy_q;
    assign pix_hit      = hit_q;
    assign pix_id       = id_q;
    assign pix_red      = rgb_q[11:8];
    assign pix_green    = rgb_q[7:4];
    assign pix_blue     = rgb_q[3:0];
    assign mode         = mode_q;
    assign game_over    = game_over_q;
    assign collision_id = coll_q;

endmodule

// File: tb/tb_ghost_sprite_engine.sv
// Directed bench for ghost_sprite_engine: FSM sequences plus a pixel vector table.
// Built with NUM_GHOSTS = 4 and MODE_FRAMES = 4.
module tb_ghost_sprite_engine;

    localparam int N  = 4;
    localparam int CW = 10;

    logic          Clk = 1'b0;
    logic          reset_rtl_0;
    logic          frame_tick;
    logic          start;
    logic [CW-1:0] draw_x, draw_y;
    logic          draw_valid;
    logic [CW-1:0] pacman_x, pacman_y;
    logic [N*CW-1:0] ghost_x, ghost_y;
    logic          pix_hit;
    logic [2:0]    pix_id;
    logic [3:0]    pix_red, pix_green, pix_blue;
    logic          mode, game_over;
    logic [2:0]    collision_id;
`ifdef GHOST_FRIGHTENED_EN
    logic          power_pellet;
    logic          ghost_eaten;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #20 Clk = ~Clk;

    ghost_sprite_engine #(
        .NUM_GHOSTS (N),
        .MODE_FRAMES(4)
    ) dut (
        .Clk         (Clk),
        .reset_rtl_0 (reset_rtl_0),
        .frame_tick  (frame_tick),
        .start       (start),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_valid  (draw_valid),
        .pacman_x    (pacman_x),
        .pacman_y    (pacman_y),
`ifdef GHOST_FRIGHTENED_EN
        .power_pellet(power_pellet),
        .ghost_eaten (ghost_eaten),
`endif
        .ghost_x     (ghost_x),
        .ghost_y     (ghost_y),
        .pix_hit     (pix_hit),
        .pix_id      (pix_id),
        .pix_red     (pix_red),
        .pix_green   (pix_green),
        .pix_blue    (pix_blue),
        .mode        (mode),
        .game_over   (game_over),
        .collision_id(collision_id)
    );

    typedef struct {
        int x, y, v;
        int hit, id, r, g, b;
    } pv_t;

    pv_t tbl [10];

    function automatic int gx(input int i);
        return int'(ghost_x[i*CW +: CW]);
    endfunction

    function automatic int gy(input int i);
        return int'(ghost_y[i*CW +: CW]);
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic frame();
        @(negedge Clk) frame_tick = 1'b1;
        repeat (2) @(negedge Clk);
        frame_tick = 1'b0;
        repeat (8) @(negedge Clk);
    endtask

    task automatic pulse_start();
        @(negedge Clk) start = 1'b1;
        @(negedge Clk) start = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        tbl[0] = '{290, 230, 1, 1, 0, 15, 0, 0};
        tbl[1] = '{319, 230, 1, 1, 1, 15, 11, 11};
        tbl[2] = '{321, 230, 1, 1, 2, 0, 15, 15};
        tbl[3] = '{352, 239, 1, 1, 3, 15, 11, 4};
        tbl[4] = '{353, 230, 1, 0, 0, 0, 0, 0};
        tbl[5] = '{287, 224, 1, 1, 0, 15, 0, 0};
        tbl[6] = '{286, 224, 1, 0, 0, 0, 0, 0};
        tbl[7] = '{290, 240, 1, 0, 0, 0, 0, 0};
        tbl[8] = '{290, 230, 0, 0, 0, 0, 0, 0};
        tbl[9] = '{320, 239, 1, 1, 1, 15, 11, 11};

        reset_rtl_0 = 1'b0;
        frame_tick  = 1'b0;
        start       = 1'b0;
        draw_x      = '0;
        draw_y      = '0;
        draw_valid  = 1'b0;
        pacman_x    = '0;
        pacman_y    = '0;
`ifdef GHOST_FRIGHTENED_EN
        power_pellet = 1'b0;
`endif
        repeat (3) @(negedge Clk);
        chk("rst_pix_hit", int'(pix_hit), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_g0x", gx(0), 288);
        reset_rtl_0 = 1'b1;

        repeat (5) frame();
        chk("idle_g0x", gx(0), 288);
        chk("idle_g0y", gy(0), 224);
        chk("idle_g3x", gx(3), 336);
        chk("idle_g3y", gy(3), 224);
        chk("idle_game_over", int'(game_over), 0);
        chk("idle_mode", int'(mode), 0);

        pulse_start();
        chk("start_g0x", gx(0), 288);

        // Second rising edge lands mid-UPDATE and must be dropped.
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
        @(negedge Clk) frame_tick = 1'b1;
        repeat (10) @(negedge Clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge Clk);
        chk("f1_g0x", gx(0), 287);
        chk("f1_g1x", gx(1), 305);
        chk("f1_g2x", gx(2), 319);
        chk("f1_g3x", gx(3), 337);
        chk("f1_g0y", gy(0), 224);
        chk("f1_mode", int'(mode), 0);

        frame();
        pulse_start();
        frame();
        chk("f3_mode", int'(mode), 0);
        chk("f3_g0x", gx(0), 285);
        chk("f3_g3x", gx(3), 339);

        pacman_x = 285;
        pacman_y = 400;
        frame();
        chk("f4_mode", int'(mode), 1);
        chk("f4_g0x", gx(0), 285);
        chk("f4_g0y", gy(0), 225);
        chk("f4_g1y", gy(1), 225);
        chk("f4_game_over", int'(game_over), 0);

        pacman_y = 228;
        frame();
        chk("f5_g0x", gx(0), 285);
        chk("f5_g0y", gy(0), 226);
        chk("f5_g1x", gx(1), 306);
        chk("f5_game_over", int'(game_over), 1);
        chk("f5_coll_id", int'(collision_id), 0);

        frame();
        chk("over_g0y", gy(0), 226);
        chk("over_g1x", gx(1), 306);
        chk("over_game_over", int'(game_over), 1);

        pulse_start();
        chk("restart_g0x", gx(0), 288);
        chk("restart_g0y", gy(0), 224);
        chk("restart_g3x", gx(3), 336);
        chk("restart_game_over", int'(game_over), 0);
        chk("restart_mode", int'(mode), 0);

        pacman_x = 300;
        pacman_y = 224;
        frame();
        chk("hit_game_over", int'(game_over), 1);
        chk("hit_coll_id", int'(collision_id), 0);
        chk("hit_g0x", gx(0), 287);
        chk("hit_g1x", gx(1), 305);
        chk("hit_g2x", gx(2), 319);

        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            draw_x     = CW'(tbl[k].x);
            draw_y     = CW'(tbl[k].y);
            draw_valid = (tbl[k].v != 0);
            @(negedge Clk);
            chk($sformatf("pix%0d_hit", k), int'(pix_hit), tbl[k].hit);
            chk($sformatf("pix%0d_id", k), int'(pix_id), tbl[k].id);
            chk($sformatf("pix%0d_r", k), int'(pix_red), tbl[k].r);
            chk($sformatf("pix%0d_g", k), int'(pix_green), tbl[k].g);
            chk($sformatf("pix%0d_b", k), int'(pix_blue), tbl[k].b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
